// File: rtl/qspi_bus_arbiter.sv
// Shares the quad-SPI pad group between the fetch (m0) and load/store (m1) controllers,
// enforcing a chip-select-high gap and applying the boot-selected input sample delay.
module qspi_bus_arbiter #(
  parameter int GAP_CYCLES   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cfg_sample_dly,
  input  logic       m0_req,
  input  logic       m0_sel,
  output logic       m0_gnt,
  input  logic       m0_cs_n,
  input  logic       m0_sclk,
  input  logic [3:0] m0_io_out,
  input  logic [3:0] m0_io_oe,
  output logic [3:0] m0_io_in,
  input  logic       m1_req,
  input  logic       m1_sel,
  output logic       m1_gnt,
  input  logic       m1_cs_n,
  input  logic       m1_sclk,
  input  logic [3:0] m1_io_out,
  input  logic [3:0] m1_io_oe,
  output logic [3:0] m1_io_in,
  output logic       flash_cs_n,
  output logic       ram_cs_n,
  output logic       bus_sclk,
  output logic [3:0] bus_io_out,
  output logic [3:0] bus_io_oe,
  input  logic [3:0] bus_io_in,
  output logic       proto_err
);

  localparam logic [2:0] GapLoad = 3'(GAP_CYCLES);
  localparam logic [3:0] SkipMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_e;

  state_e     state_q, state_d;
  logic [2:0] gap_q, gap_d;
  logic [3:0] skip_q, skip_d;
  logic       proto_q, proto_d;

  state_e     arb_state;
  logic [3:0] arb_skip;
  logic       owner_req;

  logic [1:0] dly_q;
  logic       cap_q;
  logic [3:0] d1_q, d2_q, d3_q;
  logic [3:0] io_in_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      skip_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      skip_q  <= skip_d;
      proto_q <= proto_d;
    end
  end

  // m1 may lose at most SkipMax contended rounds in a row before it is forced through.
  always_comb begin
    arb_state = IDLE;
    arb_skip  = skip_q;
    if (m0_req && m1_req) begin
      if (skip_q < SkipMax) begin
        arb_state = OWN0;
        arb_skip  = skip_q + 4'd1;
      end else begin
        arb_state = OWN1;
        arb_skip  = '0;
      end
    end else if (m1_req) begin
      arb_state = OWN1;
      arb_skip  = '0;
    end else if (m0_req) begin
      arb_state = OWN0;
    end
  end

  assign owner_req = (state_q == OWN1) ? m1_req : m0_req;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    skip_d  = skip_q;
    proto_d = ((state_q == OWN0) && !m0_req && !m0_cs_n) ||
              ((state_q == OWN1) && !m1_req && !m1_cs_n);
    case (state_q)
      IDLE: begin
        state_d = arb_state;
        skip_d  = arb_skip;
      end
      OWN0, OWN1: begin
        if (!owner_req) begin
          if (GAP_CYCLES == 0) begin
            state_d = arb_state;
            skip_d  = arb_skip;
          end else begin
            state_d = GAP;
            gap_d   = GapLoad;
          end
        end
      end
      GAP: begin
        if (gap_q <= 3'd1) begin
          state_d = arb_state;
          skip_d  = arb_skip;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flash_cs_n = 1'b1;
    ram_cs_n   = 1'b1;
    bus_sclk   = 1'b0;
    bus_io_out = '0;
    bus_io_oe  = '0;
    case (state_q)
      OWN0: begin
        flash_cs_n = m0_cs_n | m0_sel;
        ram_cs_n   = m0_cs_n | !m0_sel;
        bus_sclk   = m0_sclk;
        bus_io_out = m0_io_out;
        bus_io_oe  = m0_io_oe;
      end
      OWN1: begin
        flash_cs_n = m1_cs_n | m1_sel;
        ram_cs_n   = m1_cs_n | !m1_sel;
        bus_sclk   = m1_sclk;
        bus_io_out = m1_io_out;
        bus_io_oe  = m1_io_oe;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = (state_q == OWN0);
  assign m1_gnt    = (state_q == OWN1);
  assign proto_err = proto_q;

  // The boot strap is latched once so the pins can be reused as GPIO afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
      cap_q <= 1'b0;
      d1_q  <= '0;
      d2_q  <= '0;
      d3_q  <= '0;
    end else begin
      d1_q <= bus_io_in;
      d2_q <= d1_q;
      d3_q <= d2_q;
      if (!cap_q) begin
        dly_q <= cfg_sample_dly;
        cap_q <= 1'b1;
      end
    end
  end

  always_comb begin
    case (dly_q)
      2'd1:    io_in_dly = d1_q;
      2'd2:    io_in_dly = d2_q;
      2'd3:    io_in_dly = d3_q;
      default: io_in_dly = bus_io_in;
    endcase
  end

  assign m0_io_in = cap_q ? io_in_dly : 4'h0;
  assign m1_io_in = cap_q ? io_in_dly : 4'h0;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Self-checking bench for qspi_bus_arbiter: directed steps plus randomized traffic
// checked every cycle against a timeline-based reference model.
module tb_qspi_bus_arbiter;

  localparam int GAPC  = 2;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg;
  logic [1:0] req, sel, csN, sclk;
  logic [3:0] ioOut [2];
  logic [3:0] ioOe  [2];
  logic [3:0] busIoIn;

  logic       gnt0A, gnt1A, flashA, ramA, sclkA, protoA;
  logic [3:0] busOutA, busOeA, ioIn0A, ioIn1A;

  logic [1:0] bReq, bSel, bCsN;
  logic       gnt0B, gnt1B, flashB, ramB, sclkB, protoB;
  logic [3:0] busOutB, busOeB, ioIn0B, ioIn1B;

  int nAsserts = 0;
  int nFail    = 0;

  int         ownerM;
  int         nextArb;
  int         cyc;
  int         skipM;
  logic       protoM;
  logic       capM;
  logic [1:0] dlyM;
  logic [3:0] hist [3];

  always #5 clk = ~clk;

  qspi_bus_arbiter #(.GAP_CYCLES(GAPC), .STARVE_LIMIT(LIMIT)) dutA (
    .clk(clk), .rst_n(rst_n), .cfg_sample_dly(cfg),
    .m0_req(req[0]), .m0_sel(sel[0]), .m0_gnt(gnt0A), .m0_cs_n(csN[0]), .m0_sclk(sclk[0]),
    .m0_io_out(ioOut[0]), .m0_io_oe(ioOe[0]), .m0_io_in(ioIn0A),
    .m1_req(req[1]), .m1_sel(sel[1]), .m1_gnt(gnt1A), .m1_cs_n(csN[1]), .m1_sclk(sclk[1]),
    .m1_io_out(ioOut[1]), .m1_io_oe(ioOe[1]), .m1_io_in(ioIn1A),
    .flash_cs_n(flashA), .ram_cs_n(ramA), .bus_sclk(sclkA), .bus_io_out(busOutA),
    .bus_io_oe(busOeA), .bus_io_in(busIoIn), .proto_err(protoA)
  );

  qspi_bus_arbiter #(.GAP_CYCLES(0), .STARVE_LIMIT(LIMIT)) dutB (
    .clk(clk), .rst_n(rst_n), .cfg_sample_dly(cfg),
    .m0_req(bReq[0]), .m0_sel(bSel[0]), .m0_gnt(gnt0B), .m0_cs_n(bCsN[0]), .m0_sclk(sclk[0]),
    .m0_io_out(ioOut[0]), .m0_io_oe(ioOe[0]), .m0_io_in(ioIn0B),
    .m1_req(bReq[1]), .m1_sel(bSel[1]), .m1_gnt(gnt1B), .m1_cs_n(bCsN[1]), .m1_sclk(sclk[1]),
    .m1_io_out(ioOut[1]), .m1_io_oe(ioOe[1]), .m1_io_in(ioIn1B),
    .flash_cs_n(flashB), .ram_cs_n(ramB), .bus_sclk(sclkB), .bus_io_out(busOutB),
    .bus_io_oe(busOeB), .bus_io_in(busIoIn), .proto_err(protoB)
  );

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkNib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    ownerM  = -1;
    nextArb = 0;
    cyc     = 0;
    skipM   = 0;
    protoM  = 1'b0;
    capM    = 1'b0;
    dlyM    = 2'd0;
    for (int i = 0; i < 3; i++) hist[i] = 4'h0;
  endtask

  task automatic arbitrateModel();
    if (req[0] && req[1]) begin
      if (skipM < LIMIT) begin
        ownerM = 0;
        skipM++;
      end else begin
        ownerM = 1;
        skipM  = 0;
      end
    end else if (req[1]) begin
      ownerM = 1;
      skipM  = 0;
    end else if (req[0]) begin
      ownerM = 0;
    end else begin
      ownerM = -1;
    end
  endtask

  // Bus ownership tracked as a timeline: after a release, arbitration is barred until edge release+GAPC.
  task automatic modelEdge();
    protoM = 1'b0;
    if (ownerM >= 0) begin
      if (!req[ownerM]) begin
        protoM = !csN[ownerM];
        if (GAPC == 0) arbitrateModel();
        else begin
          ownerM  = -1;
          nextArb = cyc + GAPC;
        end
      end
    end else if (cyc >= nextArb) begin
      arbitrateModel();
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = busIoIn;
    if (!capM) begin
      dlyM = cfg;
      capM = 1'b1;
    end
    cyc++;
  endtask

  task automatic checkOutput(input string tag);
    logic       eFlash, eRam, eSclk;
    logic [3:0] eOut, eOe, eIn;
    eFlash = 1'b1; eRam = 1'b1; eSclk = 1'b0; eOut = 4'h0; eOe = 4'h0;
    if (ownerM >= 0) begin
      eFlash = !(!csN[ownerM] && !sel[ownerM]);
      eRam   = !(!csN[ownerM] && sel[ownerM]);
      eSclk  = sclk[ownerM];
      eOut   = ioOut[ownerM];
      eOe    = ioOe[ownerM];
    end
    if (!capM)             eIn = 4'h0;
    else if (dlyM == 2'd0) eIn = busIoIn;
    else                   eIn = hist[dlyM - 2'd1];
    checkBit($sformatf("%s_gnt0", tag), gnt0A, ownerM == 0);
    checkBit($sformatf("%s_gnt1", tag), gnt1A, ownerM == 1);
    checkBit($sformatf("%s_flash", tag), flashA, eFlash);
    checkBit($sformatf("%s_ram", tag), ramA, eRam);
    checkBit($sformatf("%s_sclk", tag), sclkA, eSclk);
    checkNib($sformatf("%s_out", tag), busOutA, eOut);
    checkNib($sformatf("%s_oe", tag), busOeA, eOe);
    checkBit($sformatf("%s_proto", tag), protoA, protoM);
    checkNib($sformatf("%s_in0", tag), ioIn0A, eIn);
    checkNib($sformatf("%s_in1", tag), ioIn1A, eIn);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput($sformatf("c%0d", cyc));
  endtask

  task automatic applyStimulus(input logic r0, input logic s0, input logic c0,
                               input logic r1, input logic s1, input logic c1);
    req[0] = r0; sel[0] = s0; csN[0] = c0;
    req[1] = r1; sel[1] = s1; csN[1] = c1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    sclk = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ioOut[i] = 4'h0;
      ioOe[i]  = 4'h0;
    end
    busIoIn = 4'h0;
    bReq = 2'b00; bSel = 2'b00; bCsN = 2'b11;
  endtask

  task automatic doReset(input logic [1:0] cfgVal);
    @(negedge clk);
    rst_n = 1'b0;
    cfg   = cfgVal;
    idleInputs();
    resetModel();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
  endtask

  task automatic randomDrive();
    for (int i = 0; i < 2; i++) begin
      if (!req[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          sel[i] = 1'($urandom_range(0, 1));
        end
      end else if (ownerM == i && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b0;
      end
      csN[i]   = 1'($urandom_range(0, 1));
      sclk[i]  = 1'($urandom_range(0, 1));
      ioOut[i] = 4'($urandom);
      ioOe[i]  = 4'($urandom);
    end
    busIoIn = 4'($urandom);
    cfg     = 2'($urandom);
  endtask

  initial begin
    bit   order [$];
    bit   expOrder [10];
    logic prev0, prev1;
    int   idleRun;
    int   dlyList [4];

    rst_n = 1'b0;
    cfg   = 2'd0;
    idleInputs();
    resetModel();

    // Single transaction on m0 to flash, then release and gap.
    doReset(2'd0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ioOut[0] = 4'hA; ioOe[0] = 4'hF; sclk[0] = 1'b1;
    step();
    checkBit("single_gnt", gnt0A, 1'b1);
    checkBit("single_flash", flashA, 1'b0);
    checkBit("single_ram", ramA, 1'b1);
    checkNib("single_out", busOutA, 4'hA);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checkBit("rel1_gnt", gnt0A, 1'b0);
    checkBit("rel1_flash", flashA, 1'b1);
    checkBit("rel1_ram", ramA, 1'b1);
    step();
    checkBit("rel2_flash", flashA, 1'b1);
    checkBit("rel2_ram", ramA, 1'b1);
    step();

    // Sample delay latched at reset release; later pin changes are ignored.
    dlyList = '{2, 0, 1, 3};
    foreach (dlyList[k]) begin
      doReset(2'(dlyList[k]));
      step();
      cfg = 2'd0;
      step(); step(); step();
      busIoIn = 4'h5;
      #1;
      checkNib($sformatf("dly%0d_t0", dlyList[k]), ioIn0A, (dlyList[k] == 0) ? 4'h5 : 4'h0);
      for (int i = 1; i <= 3; i++) begin
        step();
        checkNib($sformatf("dly%0d_t%0d_m0", dlyList[k], i), ioIn0A, (i >= dlyList[k]) ? 4'h5 : 4'h0);
        checkNib($sformatf("dly%0d_t%0d_m1", dlyList[k], i), ioIn1A, (i >= dlyList[k]) ? 4'h5 : 4'h0);
      end
    end

    // Owner drops req with CS still asserted.
    doReset(2'd1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    checkBit("perr_own", gnt1A, 1'b1);
    checkBit("perr_ram0", ramA, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    checkBit("perr_pulse", protoA, 1'b1);
    checkBit("perr_ram1", ramA, 1'b1);
    checkBit("perr_flash1", flashA, 1'b1);
    checkBit("perr_gnt1", gnt1A, 1'b0);
    step();
    checkBit("perr_clear", protoA, 1'b0);
    checkBit("perr_gap", gnt0A, 1'b0);
    step();
    checkBit("perr_next", gnt0A, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); step(); step();

    // Continuous contention with one-cycle transactions.
    doReset(2'd0);
    step();
    prev0 = 1'b0; prev1 = 1'b0; idleRun = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (ownerM == i && req[i]) req[i] = 1'b0;
        else begin
          if (!req[i]) sel[i] = 1'($urandom_range(0, 1));
          req[i] = 1'b1;
        end
      end
      csN = 2'b11;
      step();
      checkBit("excl", gnt0A & gnt1A, 1'b0);
      if ((gnt0A && !prev0) || (gnt1A && !prev1)) begin
        if (order.size() > 0) checkBit("gaplen", idleRun >= GAPC, 1'b1);
        order.push_back(gnt1A);
        idleRun = 0;
      end else if (!gnt0A && !gnt1A) begin
        idleRun++;
      end
      prev0 = gnt0A; prev1 = gnt1A;
    end
    expOrder = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    checkBit("order_len", order.size() >= 10, 1'b1);
    for (int k = 0; k < 10 && k < order.size(); k++)
      checkBit($sformatf("order%0d", k), order[k], expOrder[k]);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); step(); step();

    // Zero-gap instance: m1 takes over in the cycle right after m0 releases.
    doReset(2'd0);
    step();
    bReq = 2'b11; bSel = 2'b10; bCsN = 2'b00;
    sclk[1] = 1'b1; ioOut[1] = 4'h3; ioOe[1] = 4'hC;
    step();
    checkBit("g0_gnt0", gnt0B, 1'b1);
    checkBit("g0_gnt1w", gnt1B, 1'b0);
    checkBit("g0_flash", flashB, 1'b0);
    bReq[0] = 1'b0; bCsN[0] = 1'b1;
    busIoIn = 4'h9;
    step();
    checkBit("g0_rel", gnt0B, 1'b0);
    checkBit("g0_gnt1", gnt1B, 1'b1);
    checkBit("g0_ram", ramB, 1'b0);
    checkBit("g0_flash1", flashB, 1'b1);
    checkBit("g0_sclk", sclkB, 1'b1);
    checkNib("g0_out", busOutB, 4'h3);
    checkNib("g0_oe", busOeB, 4'hC);
    checkBit("g0_proto", protoB, 1'b0);
    checkNib("g0_in0", ioIn0B, 4'h9);
    checkNib("g0_in1", ioIn1B, 4'h9);
    bCsN[1] = 1'b1;
    #1;
    checkBit("g0_ramfollow", ramB, 1'b1);
    bReq = 2'b00;
    step(); step();

    // Asynchronous reset while m1 drives the PSRAM.
    doReset(2'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    sclk[1] = 1'b1; ioOut[1] = 4'hF; ioOe[1] = 4'hF; busIoIn = 4'h7;
    step();
    checkBit("ar_pre_gnt", gnt1A, 1'b1);
    checkBit("ar_pre_ram", ramA, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkBit("ar_gnt0", gnt0A, 1'b0);
    checkBit("ar_gnt1", gnt1A, 1'b0);
    checkBit("ar_flash", flashA, 1'b1);
    checkBit("ar_ram", ramA, 1'b1);
    checkBit("ar_sclk", sclkA, 1'b0);
    checkNib("ar_out", busOutA, 4'h0);
    checkNib("ar_oe", busOeA, 4'h0);
    checkBit("ar_proto", protoA, 1'b0);
    checkNib("ar_in0", ioIn0A, 4'h0);
    checkNib("ar_in1", ioIn1A, 4'h0);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 3; r++) begin
      doReset(2'($urandom_range(0, 3)));
      step();
      for (int c = 0; c < 300; c++) begin
        randomDrive();
        step();
      end
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/qspi_bus_arbiter.md
# qspi_bus_arbiter

Shares the single quad-SPI pad group (`bus_sclk`, `bus_io[3:0]`, `flash_cs_n`, `ram_cs_n`) between two bus masters: m0, the instruction-fetch QSPI controller, and m1, the load/store QSPI controller. Each master can target either the flash or the PSRAM. The block arbitrates ownership and enforces a minimum chip-select-high gap between transactions. It also applies the boot-mode-selected 0–3 cycle sample delay to the returning `bus_io_in` data. It sits between the two controllers and the `uio` pin mux in `soc`.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: minimum cycles with both CS high between two granted transactions; legal range 0–7.
- `STARVE_LIMIT`, default 4: consecutive contended arbitrations m1 may lose before it wins; legal range 1–15.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_sample_dly` in 2: input sample delay in cycles (0–3); driven from `gpio_in[5:4]` (boot mode).
- `mX_req` in 1 (X = 0, 1): master requests the bus; held for the whole transaction.
- `mX_sel` in 1: target device; 0 = flash, 1 = PSRAM; must be stable while `mX_req` is high.
- `mX_gnt` out 1: master owns the bus.
- `mX_cs_n` in 1: master's chip select, active-low.
- `mX_sclk` in 1: master's serial clock.
- `mX_io_out` in 4: master's output data.
- `mX_io_oe` in 4: master's output enables.
- `mX_io_in` out 4: delayed pad input, broadcast to both masters.
- `flash_cs_n` out 1: flash chip select pad.
- `ram_cs_n` out 1: PSRAM chip select pad.
- `bus_sclk` out 1: shared serial clock pad.
- `bus_io_out` out 4: shared data output pads.
- `bus_io_oe` out 4: shared data output enables.
- `bus_io_in` in 4: shared data input pads.
- `proto_err` out 1: one-cycle pulse on a master protocol violation.

## Operation
- States: IDLE, OWN0, OWN1, GAP.
  - `m0_gnt` = (state == OWN0); `m1_gnt` = (state == OWN1).
  - Both grants are registered outputs and are never high together.
- Arbitration runs in IDLE, and in GAP when the gap counter expires:
  - Only one master requesting: that master wins.
  - Both requesting and `skip_cnt` < `STARVE_LIMIT`: m0 wins and `skip_cnt` increments.
  - Both requesting and `skip_cnt` == `STARVE_LIMIT`: m1 wins.
  - Any m1 win clears `skip_cnt`.
  - No request: go to IDLE.
- OWNx: when `mX_req` is sampled low, go to GAP and load `gap_cnt` = `GAP_CYCLES`.
  - With `GAP_CYCLES` = 0, arbitrate immediately instead: go to the next OWN state or to IDLE.
- GAP: `gap_cnt` decrements each cycle; at 1 it arbitrates as above.
- Pad mux is combinational from state; owner m = granted master.
  - `flash_cs_n` = !(granted && !`m_cs_n` && !`m_sel`).
  - `ram_cs_n` = !(granted && !`m_cs_n` && `m_sel`).
  - `bus_sclk`, `bus_io_out` and `bus_io_oe` come from the owner.
- Not granted (IDLE or GAP): both CS = 1, `bus_sclk` = 0, `bus_io_out` = 0, `bus_io_oe` = 0.
- `proto_err` pulses for one cycle when the owner drops `mX_req` while `mX_cs_n` = 0 in the same cycle. The arbiter still proceeds to GAP, which forces CS high.
- Sample delay:
  - `cfg_sample_dly` is captured into `dly_q` on the first clock edge after `rst_n` rises. It is ignored afterwards until the next reset, so the pins are free for use as GPIO.
  - `bus_io_in` feeds a 3-stage register pipeline d1 → d2 → d3.
  - `mX_io_in` = `bus_io_in` when `dly_q` = 0, d1 when 1, d2 when 2, d3 when 3.

## Timing
- Reset values:
  - Outputs: both grants 0, both CS 1, `bus_sclk` 0, `bus_io_out` 0, `bus_io_oe` 0, `proto_err` 0, `mX_io_in` 0.
  - Internal: state IDLE, `skip_cnt` 0, `gap_cnt` 0, `dly_q` 0 with a captured flag clear, d1–d3 = 0.
- Grant latency: `mX_req` sampled high at edge k in IDLE → `mX_gnt` = 1 after edge k.
- Release: `mX_req` sampled low at edge k → grant 0 after edge k.
  - Next grant at the earliest after edge k + `GAP_CYCLES`.
  - CS high for at least `GAP_CYCLES` full cycles.
- Data delay: a `bus_io_in` value appears on `mX_io_in` exactly `dly_q` cycles later.
- Reset mid-transaction: outputs return asynchronously to their reset values. The transaction is abandoned; masters must also reset.
- A master re-raising `req` during its own GAP is treated as a new request.

## Test plan
- Single request: m0 requests with `m0_sel` = 0 and drives `m0_cs_n` = 0, `m0_io_out` = 4'hA.
  - Required: `m0_gnt` one cycle later, `flash_cs_n` = 0, `ram_cs_n` = 1, `bus_io_out` = A.
  - Drop `m0_req`: 2 cycles of both CS high, `m0_gnt` = 0.
- Contention, `STARVE_LIMIT` = 4: both masters request continuously with 1-cycle transactions.
  - Required grant order: m0, m0, m0, m0, m1, m0, …
  - Check both grants are never high together and every gap is ≥ 2 cycles.
- Sample delay: hold `cfg_sample_dly` = 2 through reset release, then change it to 0; drive `bus_io_in` 0 → 5.
  - Required: `mX_io_in` changes to 5 exactly 2 cycles later, and the delay stays 2 after the pin change.
  - Repeat the check for delays 0, 1 and 3.
- Protocol error: owner drops `req` with `cs_n` = 0.
  - Required: `proto_err` pulses for 1 cycle, both CS go to 1 the next cycle, and the GAP is enforced.
- `GAP_CYCLES` = 0 with m1 waiting: m0 releases.
  - Required: `m1_gnt` = 1 in the cycle immediately after `m0_gnt` falls, with `ram_cs_n` following `m1_cs_n` and `m1_sel` = 1.
- Async reset while `m1_gnt` = 1 and `ram_cs_n` = 0.
  - Required: all outputs at reset values immediately, before the next clock edge.
